// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit_if : pipeline request/response and memory bus       |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  SLCtrl;
   logic        req_ready;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        rsp_valid;
   logic [31:0] memD;
   logic [1:0]  bytesel;
   logic [2:0]  SLCtrl_out;
   logic        exc_adel;
   logic        exc_ades;
   logic        bus_err;

   // master: the access unit itself
   modport master (
      input  req_valid, req_we, req_addr, req_wdata, SLCtrl, bus_ack, bus_rdata,
      output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
             rsp_valid, memD, bytesel, SLCtrl_out, exc_adel, exc_ades, bus_err
   );

   // slave: pipeline plus memory environment around the unit
   modport slave (
      output req_valid, req_we, req_addr, req_wdata, SLCtrl, bus_ack, bus_rdata,
      input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
             rsp_valid, memD, bytesel, SLCtrl_out, exc_adel, exc_ades, bus_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit : load/store to word bus with lanes and timeout     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_access_unit #(
   parameter int TIMEOUT_CYC = 16
) (
   input wire logic           clk,
   input wire logic           reset,
   mem_access_unit_if.master  mau
);

   localparam logic [2:0] c_slword      = 3'd0;
   localparam logic [2:0] c_slhalf      = 3'd1;
   localparam logic [2:0] c_slbyte      = 3'd2;
   localparam logic [2:0] c_slhalfu     = 3'd3;
   localparam logic [2:0] c_slbyteu     = 3'd4;
   localparam logic [2:0] c_slwordleft  = 3'd5;
   localparam logic [2:0] c_slwordright = 3'd6;
   localparam logic [7:0] c_limit       = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] memd_q, memd_d;
   logic [1:0]  bytesel_q, bytesel_d;
   logic [2:0]  slctrl_q, slctrl_d;
   logic        adel_q, adel_d;
   logic        ades_q, ades_d;
   logic        err_q, err_d;

   logic [1:0]  lane_a;
   logic [3:0]  lane_be;
   logic [31:0] lane_data;
   logic        misaligned;

   assign lane_a = mau.req_addr[1:0];

   always_comb begin
      lane_be    = 4'b0000;
      lane_data  = 32'd0;
      misaligned = 1'b0;
      case (mau.SLCtrl)
         c_slword: begin
            lane_be    = 4'b1111;
            lane_data  = mau.req_wdata;
            misaligned = (lane_a != 2'b00);
         end
         c_slhalf, c_slhalfu: begin
            lane_be    = 4'b0011 << {lane_a[1], 1'b0};
            lane_data  = mau.req_wdata << {lane_a[1], 4'b0000};
            misaligned = lane_a[0];
         end
         c_slbyte, c_slbyteu: begin
            lane_be   = 4'b0001 << lane_a;
            lane_data = mau.req_wdata << {lane_a, 3'b000};
         end
         // left-part store keeps the high-order bytes of the register
         c_slwordleft: begin
            lane_be   = 4'b1111 >> (2'd3 - lane_a);
            lane_data = mau.req_wdata >> {(2'd3 - lane_a), 3'b000};
         end
         c_slwordright: begin
            lane_be   = 4'b1111 << lane_a;
            lane_data = mau.req_wdata << {lane_a, 3'b000};
         end
         default: begin
            lane_be   = 4'b0000;
            lane_data = 32'd0;
         end
      endcase
      if (!mau.req_we) begin
         lane_be   = 4'b0000;
         lane_data = 32'd0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      we_d      = we_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      memd_d    = memd_q;
      bytesel_d = bytesel_q;
      slctrl_d  = slctrl_q;
      adel_d    = adel_q;
      ades_d    = ades_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            if (mau.req_valid) begin
               addr_d    = {mau.req_addr[31:2], 2'b00};
               we_d      = mau.req_we;
               be_d      = lane_be;
               wdata_d   = lane_data;
               memd_d    = 32'd0;
               bytesel_d = lane_a;
               slctrl_d  = mau.SLCtrl;
               cnt_d     = 8'd0;
               if (misaligned) begin
                  adel_d  = ~mau.req_we;
                  ades_d  = mau.req_we;
                  state_d = RESP;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            // an ack on the final allowed cycle wins over the timeout
            if (mau.bus_ack) begin
               if (!we_q) begin
                  memd_d = mau.bus_rdata;
               end
               state_d = RESP;
            end else if (cnt_q == c_limit) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            adel_d  = 1'b0;
            ades_d  = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= 32'd0;
         we_q      <= 1'b0;
         be_q      <= 4'b0000;
         wdata_q   <= 32'd0;
         memd_q    <= 32'd0;
         bytesel_q <= 2'b00;
         slctrl_q  <= 3'd0;
         adel_q    <= 1'b0;
         ades_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         memd_q    <= memd_d;
         bytesel_q <= bytesel_d;
         slctrl_q  <= slctrl_d;
         adel_q    <= adel_d;
         ades_q    <= ades_d;
         err_q     <= err_d;
      end
   end

   // strobes decode straight from state so reset removes them without a clock
   assign mau.req_ready  = (state_q == IDLE);
   assign mau.bus_req    = (state_q == BUSY);
   assign mau.rsp_valid  = (state_q == RESP);
   assign mau.bus_we     = we_q;
   assign mau.bus_addr   = addr_q;
   assign mau.bus_be     = be_q;
   assign mau.bus_wdata  = wdata_q;
   assign mau.memD       = memd_q;
   assign mau.bytesel    = bytesel_q;
   assign mau.SLCtrl_out = slctrl_q;
   assign mau.exc_adel   = adel_q;
   assign mau.exc_ades   = ades_q;
   assign mau.bus_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_unit : directed self-checking bench, TIMEOUT_CYC = 4  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;

   localparam logic [2:0] c_slword      = 3'd0;
   localparam logic [2:0] c_slhalf      = 3'd1;
   localparam logic [2:0] c_slbyte      = 3'd2;
   localparam logic [2:0] c_slwordleft  = 3'd5;
   localparam logic [2:0] c_slwordright = 3'd6;

   logic clk;
   logic reset;
   int   passed;
   int   total;

   mem_access_unit_if mau ();

   mem_access_unit #(.TIMEOUT_CYC(4)) dut (
      .clk   (clk),
      .reset (reset),
      .mau   (mau.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] sl);
      mau.req_valid = 1'b1;
      mau.req_we    = we;
      mau.req_addr  = addr;
      mau.req_wdata = wdata;
      mau.SLCtrl    = sl;
      step();
      mau.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      total++;
      if ({mau.req_ready, mau.bus_req, mau.rsp_valid, mau.bus_err} !== 4'b1000) begin
         $display("FAIL reset_strobes got %b exp 1000",
                  {mau.req_ready, mau.bus_req, mau.rsp_valid, mau.bus_err});
      end else passed++;
      total++;
      if ({mau.memD, mau.bus_addr, mau.bus_be} !== 68'd0) begin
         $display("FAIL reset_data got memD %h addr %h be %b exp 0",
                  mau.memD, mau.bus_addr, mau.bus_be);
      end else passed++;
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_load_word();
      issue(1'b0, 32'h0000_0100, 32'd0, c_slword);
      total++;
      if ({mau.bus_req, mau.bus_we, mau.bus_be} !== 6'b100000 || mau.bus_addr !== 32'h100) begin
         $display("FAIL load_bus got req/we/be %b addr %h exp 100000 100",
                  {mau.bus_req, mau.bus_we, mau.bus_be}, mau.bus_addr);
      end else passed++;
      step();
      step();
      mau.bus_ack   = 1'b1;
      mau.bus_rdata = 32'hDEAD_BEEF;
      step();
      mau.bus_ack = 1'b0;
      total++;
      if (mau.rsp_valid !== 1'b1 || mau.bus_req !== 1'b0 || mau.memD !== 32'hDEAD_BEEF
          || mau.bytesel !== 2'b00) begin
         $display("FAIL load_rsp got rsp %b req %b memD %h bytesel %b exp 1 0 deadbeef 00",
                  mau.rsp_valid, mau.bus_req, mau.memD, mau.bytesel);
      end else passed++;
      // ack in IDLE must not disturb anything
      mau.bus_ack   = 1'b1;
      mau.bus_rdata = 32'h1234_5678;
      step();
      step();
      mau.bus_ack = 1'b0;
      total++;
      if (mau.rsp_valid !== 1'b0 || mau.req_ready !== 1'b1 || mau.memD !== 32'hDEAD_BEEF) begin
         $display("FAIL idle_ack got rsp %b ready %b memD %h exp 0 1 deadbeef",
                  mau.rsp_valid, mau.req_ready, mau.memD);
      end else passed++;
   endtask

   task automatic test_store_lanes();
      logic [2:0]  sl [5]   = '{c_slbyte, c_slwordleft, c_slword, c_slhalf, c_slwordright};
      logic [31:0] ad [5]   = '{32'h203, 32'h201, 32'h300, 32'h302, 32'h202};
      logic [31:0] wd [5]   = '{32'h0000_00A5, 32'h1122_3344, 32'hCAFE_0001, 32'h1234_5678,
                                32'h1122_3344};
      logic [3:0]  ebe [5]  = '{4'b1000, 4'b0011, 4'b1111, 4'b1100, 4'b1100};
      logic [31:0] ewd [5]  = '{32'hA500_0000, 32'h0000_1122, 32'hCAFE_0001, 32'h5678_0000,
                                32'h3344_0000};
      logic [31:0] eadr [5] = '{32'h200, 32'h200, 32'h300, 32'h300, 32'h200};
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, ad[i], wd[i], sl[i]);
         total++;
         if (mau.bus_req !== 1'b1 || mau.bus_we !== 1'b1 || mau.bus_be !== ebe[i]
             || mau.bus_wdata !== ewd[i] || mau.bus_addr !== eadr[i]) begin
            $display("FAIL store_lane%0d got req %b we %b be %b wdata %h addr %h exp 1 1 %b %h %h",
                     i, mau.bus_req, mau.bus_we, mau.bus_be, mau.bus_wdata, mau.bus_addr,
                     ebe[i], ewd[i], eadr[i]);
         end else passed++;
         mau.bus_ack   = 1'b1;
         mau.bus_rdata = 32'hFFFF_FFFF;
         step();
         mau.bus_ack = 1'b0;
         total++;
         if (mau.rsp_valid !== 1'b1 || mau.memD !== 32'd0 || mau.bytesel !== ad[i][1:0]) begin
            $display("FAIL store_rsp%0d got rsp %b memD %h bytesel %b exp 1 0 %b",
                     i, mau.rsp_valid, mau.memD, mau.bytesel, ad[i][1:0]);
         end else passed++;
         step();
      end
   endtask

   task automatic test_misaligned();
      issue(1'b0, 32'h101, 32'd0, c_slhalf);
      total++;
      if ({mau.rsp_valid, mau.bus_req, mau.exc_adel, mau.exc_ades} !== 4'b1010
          || mau.memD !== 32'd0 || mau.bytesel !== 2'b01 || mau.SLCtrl_out !== c_slhalf) begin
         $display("FAIL misalign_load got rsp/req/adel/ades %b memD %h bytesel %b sl %0d exp 1010 0 01 1",
                  {mau.rsp_valid, mau.bus_req, mau.exc_adel, mau.exc_ades}, mau.memD,
                  mau.bytesel, mau.SLCtrl_out);
      end else passed++;
      step();
      total++;
      if ({mau.rsp_valid, mau.exc_adel, mau.req_ready} !== 3'b001) begin
         $display("FAIL misalign_clear got rsp/adel/ready %b exp 001",
                  {mau.rsp_valid, mau.exc_adel, mau.req_ready});
      end else passed++;
      issue(1'b1, 32'h102, 32'h5555_5555, c_slword);
      total++;
      if ({mau.rsp_valid, mau.bus_req, mau.exc_adel, mau.exc_ades} !== 4'b1001) begin
         $display("FAIL misalign_store got rsp/req/adel/ades %b exp 1001",
                  {mau.rsp_valid, mau.bus_req, mau.exc_adel, mau.exc_ades});
      end else passed++;
      step();
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      issue(1'b0, 32'h400, 32'd0, c_slword);
      while (mau.bus_req === 1'b1 && n < 20) begin
         n++;
         step();
      end
      total++;
      if (n !== 4 || mau.rsp_valid !== 1'b1 || mau.bus_err !== 1'b1 || mau.memD !== 32'd0) begin
         $display("FAIL timeout got cycles %0d rsp %b err %b memD %h exp 4 1 1 0",
                  n, mau.rsp_valid, mau.bus_err, mau.memD);
      end else passed++;
      step();
      total++;
      if (mau.bus_err !== 1'b0 || mau.rsp_valid !== 1'b0) begin
         $display("FAIL timeout_clear got err %b rsp %b exp 0 0", mau.bus_err, mau.rsp_valid);
      end else passed++;
      issue(1'b0, 32'h404, 32'd0, c_slword);
      step();
      step();
      step();
      mau.bus_ack   = 1'b1;
      mau.bus_rdata = 32'hCAFE_F00D;
      step();
      mau.bus_ack = 1'b0;
      total++;
      if (mau.rsp_valid !== 1'b1 || mau.bus_err !== 1'b0 || mau.memD !== 32'hCAFE_F00D) begin
         $display("FAIL ack_at_limit got rsp %b err %b memD %h exp 1 0 cafef00d",
                  mau.rsp_valid, mau.bus_err, mau.memD);
      end else passed++;
      step();
   endtask

   task automatic test_reset_busy();
      int seen;
      seen = 0;
      issue(1'b0, 32'h500, 32'd0, c_slword);
      step();
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (mau.bus_req !== 1'b0 || mau.req_ready !== 1'b1) begin
         $display("FAIL reset_busy got req %b ready %b exp 0 1", mau.bus_req, mau.req_ready);
      end else passed++;
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (mau.rsp_valid !== 1'b0) seen++;
      end
      total++;
      if (seen !== 0) begin
         $display("FAIL reset_no_rsp got %0d rsp cycles exp 0", seen);
      end else passed++;
      issue(1'b0, 32'h503, 32'd0, c_slbyte);
      mau.bus_ack   = 1'b1;
      mau.bus_rdata = 32'h1122_3344;
      step();
      mau.bus_ack = 1'b0;
      total++;
      if (mau.rsp_valid !== 1'b1 || mau.memD !== 32'h1122_3344 || mau.bytesel !== 2'b11
          || mau.SLCtrl_out !== c_slbyte) begin
         $display("FAIL after_reset got rsp %b memD %h bytesel %b sl %0d exp 1 11223344 11 2",
                  mau.rsp_valid, mau.memD, mau.bytesel, mau.SLCtrl_out);
      end else passed++;
      step();
      total++;
      if (mau.memD !== 32'h1122_3344 || mau.bytesel !== 2'b11 || mau.rsp_valid !== 1'b0) begin
         $display("FAIL hold_fields got memD %h bytesel %b rsp %b exp 11223344 11 0",
                  mau.memD, mau.bytesel, mau.rsp_valid);
      end else passed++;
   endtask

   initial begin
      passed        = 0;
      total         = 0;
      mau.req_valid = 1'b0;
      mau.req_we    = 1'b0;
      mau.req_addr  = 32'd0;
      mau.req_wdata = 32'd0;
      mau.SLCtrl    = 3'd0;
      mau.bus_ack   = 1'b0;
      mau.bus_rdata = 32'd0;
      test_reset();
      test_load_word();
      test_store_lanes();
      test_misaligned();
      test_timeout();
      test_reset_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum cycles to wait for bus_ack before aborting; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store source register value.
REQ-008 SLCtrl  input  3  access kind: slword, slhalf, slbyte, slhalfu, slbyteu, slwordleft, slwordright (team define encoding).
REQ-009 req_ready  output  1  request accepted this cycle; high only in IDLE.
REQ-010 bus_req, bus_we  output  1 each  bus strobe and write flag.
REQ-011 bus_addr  output  32  word-aligned address {req_addr[31:2],2'b00}.
REQ-012 bus_be  output  4  byte enables (all zero for loads).
REQ-013 bus_wdata  output  32  lane-aligned store data.
REQ-014 bus_ack  input  1  bus completion; bus_rdata valid when high.
REQ-015 bus_rdata  input  32  read word.
REQ-016 rsp_valid  output  1  one-cycle response pulse.
REQ-017 memD  output  32  captured read word for the downstream load-extension stage.
REQ-018 bytesel  output  2  captured req_addr[1:0].
REQ-019 SLCtrl_out  output  3  captured SLCtrl.
REQ-020 exc_adel, exc_ades, bus_err  output  1 each  load misalign, store misalign, timeout; valid with rsp_valid.

Function
REQ-021 FSM states SHALL be IDLE, BUSY, RESP.
REQ-022 IDLE: req_ready=1; a request is accepted when req_valid=1; all captured fields latch on that edge.
REQ-023 Misalignment: slword needs addr[1:0]=0; slhalf/slhalfu need addr[0]=0; byte/left/right never misaligned.
REQ-024 Misaligned request: IDLE->RESP directly, no bus_req, exc_adel (load) or exc_ades (store) set, memD=0.
REQ-025 Aligned request: IDLE->BUSY; bus_req asserted from the next cycle, bus_addr/bus_we/bus_be/bus_wdata held stable until bus_ack or timeout.
REQ-026 Store lanes (a=addr[1:0]): word be=1111, data=reg; half be=0011<<(2*a[1]), data=reg<<(16*a[1]); byte be=0001<<a, data=reg<<(8a); swl be=1111>>(3-a), data=reg>>(8(3-a)); swr be=1111<<a, data=reg<<(8a).
REQ-027 BUSY: on bus_ack=1, capture bus_rdata into memD (loads only; stores leave memD=0), deassert bus_req next cycle, go to RESP.
REQ-028 BUSY timeout counter starts at 0 on entry, increments each cycle without ack; when it reaches TIMEOUT_CYC-1 without ack -> RESP with bus_err=1, memD=0.
REQ-029 bus_ack in the same cycle the counter hits its limit SHALL count as success (bus_err=0).
REQ-030 RESP: rsp_valid=1 for exactly one cycle, then IDLE; flags clear on leaving RESP.
REQ-031 bus_ack while in IDLE or RESP SHALL be ignored.
REQ-032 Latency: ack seen in cycle k of BUSY -> rsp_valid in cycle k+1; misaligned -> rsp_valid one cycle after acceptance.
REQ-033 memD, bytesel, SLCtrl_out SHALL remain stable from RESP until the next acceptance.

Reset
REQ-034 reset low SHALL asynchronously force IDLE, counter 0, and all outputs 0 except req_ready=1.
REQ-035 reset asserted in BUSY SHALL drop bus_req immediately (no wait for clock) and discard the transaction; no rsp_valid follows.

Verification
REQ-036 Load slword addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> bus_addr 0x100, be 0000, rsp_valid 1 cycle after ack, memD 0xDEADBEEF, bytesel 00.
REQ-037 Store slbyte addr 0x203, wdata 0x000000A5 -> bus_addr 0x200, be 1000, bus_wdata 0xA5000000; swl addr 0x201 wdata 0x11223344 -> be 0011, wdata 0x00001122.
REQ-038 Load slhalf addr 0x101 -> no bus_req, exc_adel=1 with rsp_valid one cycle later; store slword addr 0x102 -> exc_ades=1.
REQ-039 TIMEOUT_CYC=4, no ack -> bus_req high 4 cycles, then rsp_valid with bus_err=1, memD 0; repeat with ack on the 4th cycle -> bus_err 0.
REQ-040 Reset pulsed mid-BUSY -> bus_req falls before the next edge, state IDLE, req_ready 1, no rsp_valid; a following request completes normally.
